// File: rtl/prim_fifo_wr_arb.sv
// Round-robin write scheduler sharing one FIFO write port between N requesters,
// with per-source occupancy quotas tracked by snooping the FIFO read handshake.
module prim_fifo_wr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned Width = 16,
  parameter int unsigned Quota = 2,
  localparam int unsigned IdW  = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CntW = (Quota > 0) ? $clog2(Quota + 1) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic [N-1:0]              req_valid_i,
  output logic [N-1:0]              req_ready_o,
  input  logic [N-1:0][Width-1:0]   req_data_i,
  output logic                      fifo_wvalid_o,
  input  logic                      fifo_wready_i,
  output logic [Width+IdW-1:0]      fifo_wdata_o,
  input  logic                      fifo_rvalid_i,
  input  logic                      fifo_rready_i,
  input  logic [IdW-1:0]            fifo_rid_i,
  output logic                      fifo_clr_o,
  output logic [N-1:0][CntW-1:0]    occ_o,
  output logic                      busy_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]               r_state;
  logic [0:0]               w_state_nxt;
  logic [IdW-1:0]           r_rr_ptr;
  logic [IdW-1:0]           w_rr_ptr_nxt;
  logic [IdW-1:0]           r_lock_id;
  logic [IdW-1:0]           w_lock_id_nxt;
  logic [N-1:0][CntW-1:0]   r_occ;
  logic [N-1:0][CntW-1:0]   w_occ_nxt;

  logic [N-1:0]             w_elig;
  logic [N-1:0]             w_inc;
  logic [N-1:0]             w_dec;
  logic [N-1:0]             w_at_quota;
  logic [N-1:0]             w_empty;
  logic [IdW:0]             w_sum;
  logic [IdW-1:0]           w_cand;
  logic [IdW-1:0]           w_winner;
  logic                     w_win_found;
  logic [IdW-1:0]           w_gnt_id;
  logic                     w_gnt_valid;
  logic                     w_run;
  logic                     w_hs;
  logic                     w_rd_hs;

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    return (id == IdW'(N - 1)) ? '0 : IdW'(id + IdW'(1));
  endfunction

  // A source may be granted only while it has room left under its quota.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_at_quota[i] = (r_occ[i] >= CntW'(Quota));
      w_empty[i]    = (r_occ[i] == '0);
      w_elig[i]     = req_valid_i[i] & ~w_at_quota[i];
    end
  end

  // First eligible index at or above rr_ptr, modulo N; lowest offset wins.
  always_comb begin
    w_win_found = 1'b0;
    w_winner    = '0;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IdW+1)'(k);
      if (w_sum >= (IdW+1)'(N)) begin
        w_sum = w_sum - (IdW+1)'(N);
      end
      w_cand = w_sum[IdW-1:0];
      if (w_elig[w_cand]) begin
        w_win_found = 1'b1;
        w_winner    = w_cand;
      end
    end
  end

  assign w_run       = rst_ni & ~clr_i;
  assign w_gnt_id    = (r_state == ST_LOCKED) ? r_lock_id : w_winner;
  assign w_gnt_valid = (r_state == ST_LOCKED) ? req_valid_i[r_lock_id] : w_win_found;

  assign fifo_wvalid_o = w_run & w_gnt_valid;
  assign fifo_wdata_o  = rst_ni ? {w_gnt_id, req_data_i[w_gnt_id]} : '0;
  assign fifo_clr_o    = clr_i | ~rst_ni;
  assign w_hs          = fifo_wvalid_o & fifo_wready_i;
  assign w_rd_hs       = fifo_rvalid_i & fifo_rready_i;

  always_comb begin
    req_ready_o = '0;
    if (fifo_wvalid_o) begin
      req_ready_o[w_gnt_id] = fifo_wready_i;
    end
  end

  // Occupancy: a write and a read of the same source in one cycle cancel out.
  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    w_occ_nxt = r_occ;
    for (int i = 0; i < int'(N); i++) begin
      w_inc[i] = w_hs & (w_gnt_id == IdW'(i));
      w_dec[i] = w_rd_hs & (fifo_rid_i == IdW'(i));
      case ({w_inc[i], w_dec[i]})
        2'b10:   w_occ_nxt[i] = r_occ[i] + CntW'(1);
        2'b01:   w_occ_nxt[i] = r_occ[i] - CntW'(1);
        default: w_occ_nxt[i] = r_occ[i];
      endcase
    end
  end

  // Next-state logic: a stalled grant is held until the FIFO accepts it.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_rr_ptr_nxt = next_id(w_winner);
        end else if (fifo_wvalid_o) begin
          w_lock_id_nxt = w_winner;
          w_state_nxt   = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_hs) begin
          w_rr_ptr_nxt = next_id(r_lock_id);
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_occ     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_occ     <= w_occ_nxt;
    end
  end

  assign occ_o  = rst_ni ? r_occ : '0;
  assign busy_o = rst_ni & ((|r_occ) | (r_state == ST_LOCKED));

  QuotaMin_A: assert property (@(posedge clk_i) (Quota >= 32'd1));

  OccOverflow_A: assert property (@(posedge clk_i) disable iff (!rst_ni || clr_i)
    !(|(w_inc & ~w_dec & w_at_quota)));

  OccUnderflow_A: assert property (@(posedge clk_i) disable iff (!rst_ni || clr_i)
    !(|(w_dec & ~w_inc & w_empty)));

  // A requester that was offered but not accepted must hold valid and data.
  ReqStable_A: assert property (@(posedge clk_i)
    (fifo_wvalid_o && !fifo_wready_i) |=>
      (!rst_ni || clr_i || (fifo_wvalid_o && $stable(fifo_wdata_o))));

endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
// Self-checking bench for prim_fifo_wr_arb: directed scenarios plus a randomized
// run compared against a queue-based model of the FIFO contents.
module tb_prim_fifo_wr_arb;

  localparam int N = 4;
  localparam int W = 16;
  localparam int Q = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][W-1:0] req_data;
  logic               wvalid;
  logic               wready;
  logic [W+1:0]       wdata;
  logic               rvalid;
  logic               rready;
  logic [1:0]         rid;
  logic               fifo_clr;
  logic [N-1:0][1:0]  occ;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  int q[$];
  int rr;
  int held;

  always #5 clk = ~clk;

  prim_fifo_wr_arb #(.N(N), .Width(W), .Quota(Q)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clr_i         (clr),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_data_i    (req_data),
    .fifo_wvalid_o (wvalid),
    .fifo_wready_i (wready),
    .fifo_wdata_o  (wdata),
    .fifo_rvalid_i (rvalid),
    .fifo_rready_i (rready),
    .fifo_rid_i    (rid),
    .fifo_clr_o    (fifo_clr),
    .occ_o         (occ),
    .busy_o        (busy)
  );

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1; req_valid = '0; rvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; req_valid = 4'hF; wready = 1'b1;
    rvalid = 1'b0; rready = 1'b0; rid = '0;
    for (int i = 0; i < N; i++) req_data[i] = W'(16'h1000 + i);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (wvalid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid c=%0d got=%b exp=0", c, wvalid); end
      n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ready c=%0d got=%h exp=0", c, req_ready); end
      n_cmp++; if (fifo_clr !== 1'b1) begin n_bad++; $display("FAIL reset_fifo_clr c=%0d got=%b exp=1", c, fifo_clr); end
      n_cmp++; if (occ !== 8'h00) begin n_bad++; $display("FAIL reset_occ c=%0d got=%h exp=0", c, occ); end
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_cmp++; if (wvalid !== 1'b1) begin n_bad++; $display("FAIL reset_first_wvalid got=%b exp=1", wvalid); end
    n_cmp++; if (wdata !== {2'd0, 16'h1000}) begin n_bad++; $display("FAIL reset_first_grant got=%h exp=%h", wdata, {2'd0, 16'h1000}); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_ready got=%b exp=0001", req_ready); end
  endtask

  task automatic test_fairness();
    int prev;
    do_clear();
    req_valid = 4'hF; wready = 1'b1; rready = 1'b1; prev = -1;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) req_data[i] = W'($urandom);
      rvalid = (prev >= 0);
      rid    = 2'(prev < 0 ? 0 : prev);
      #1;
      n_cmp++; if (wdata[W+1:W] !== 2'(k % N)) begin n_bad++; $display("FAIL fair_id k=%0d got=%0d exp=%0d", k, wdata[W+1:W], k % N); end
      n_cmp++; if (req_ready !== 4'(1 << (k % N))) begin n_bad++; $display("FAIL fair_ready k=%0d got=%b", k, req_ready); end
      for (int i = 0; i < N; i++) begin
        n_cmp++; if (occ[i] > 2'd1) begin n_bad++; $display("FAIL fair_occ k=%0d src=%0d got=%0d exp<=1", k, i, occ[i]); end
      end
      prev = k % N;
      @(negedge clk);
    end
    rvalid = 1'b0;
  endtask

  task automatic test_quota();
    do_clear();
    req_valid = 4'b0100; wready = 1'b1; rvalid = 1'b0; rready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (!(wvalid === 1'b1 && wdata[W+1:W] === 2'd2)) begin n_bad++; $display("FAIL quota_accept c=%0d wvalid=%b id=%0d exp=1/2", c, wvalid, wdata[W+1:W]); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (occ[2] !== 2'd2) begin n_bad++; $display("FAIL quota_occ got=%0d exp=2", occ[2]); end
    n_cmp++; if (wvalid !== 1'b0) begin n_bad++; $display("FAIL quota_block got=%b exp=0", wvalid); end
    @(negedge clk);
    rvalid = 1'b1; rready = 1'b1; rid = 2'd2; #1;
    n_cmp++; if (wvalid !== 1'b0) begin n_bad++; $display("FAIL quota_read_cycle got=%b exp=0", wvalid); end
    @(negedge clk);
    rvalid = 1'b0; rready = 1'b0; #1;
    n_cmp++; if (occ[2] !== 2'd1) begin n_bad++; $display("FAIL quota_occ_after_read got=%0d exp=1", occ[2]); end
    n_cmp++; if (!(wvalid === 1'b1 && wdata[W+1:W] === 2'd2)) begin n_bad++; $display("FAIL quota_regrant wvalid=%b id=%0d exp=1/2", wvalid, wdata[W+1:W]); end
    @(negedge clk);
  endtask

  task automatic test_lock();
    do_clear();
    req_data[1] = 16'hA5A1; req_data[3] = 16'h3C3C; req_data[0] = 16'h0F0F;
    wready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0) ? 4'b1010 : 4'b1011;
      #1;
      n_cmp++; if (!(wvalid === 1'b1 && wdata === {2'd1, 16'hA5A1})) begin n_bad++; $display("FAIL lock_hold c=%0d wvalid=%b wdata=%h exp=1/%h", c, wvalid, wdata, {2'd1, 16'hA5A1}); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL lock_ready c=%0d got=%b exp=0000", c, req_ready); end
      @(negedge clk);
    end
    wready = 1'b1; #1;
    n_cmp++; if (!(req_ready === 4'b0010 && wdata[W+1:W] === 2'd1)) begin n_bad++; $display("FAIL lock_release ready=%b id=%0d exp=0010/1", req_ready, wdata[W+1:W]); end
    @(negedge clk); #1;
    n_cmp++; if (!(req_ready === 4'b1000 && wdata === {2'd3, 16'h3C3C})) begin n_bad++; $display("FAIL lock_next ready=%b wdata=%h exp=1000/%h", req_ready, wdata, {2'd3, 16'h3C3C}); end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    do_clear();
    req_valid = 4'b0001; wready = 1'b1; rvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    rvalid = 1'b1; rready = 1'b1; rid = 2'd0; #1;
    n_cmp++; if (occ[0] !== 2'd1) begin n_bad++; $display("FAIL simul_occ_before got=%0d exp=1", occ[0]); end
    n_cmp++; if (wvalid !== 1'b1) begin n_bad++; $display("FAIL simul_wvalid got=%b exp=1", wvalid); end
    @(negedge clk);
    rvalid = 1'b0; rready = 1'b0; req_valid = '0; #1;
    n_cmp++; if (occ[0] !== 2'd1) begin n_bad++; $display("FAIL simul_occ_after got=%0d exp=1", occ[0]); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    logic [N-1:0][1:0] exp_occ;
    int exp_ids[4] = '{0, 1, 3, 1};
    do_clear();
    wready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c < 3) ? 4'b1011 : 4'b0010;
      #1;
      n_cmp++; if (wdata[W+1:W] !== 2'(exp_ids[c])) begin n_bad++; $display("FAIL clear_setup c=%0d got=%0d exp=%0d", c, wdata[W+1:W], exp_ids[c]); end
      @(negedge clk);
    end
    req_valid = 4'b0100; wready = 1'b0;
    @(negedge clk);
    clr = 1'b1; wready = 1'b1; #1;
    exp_occ[0] = 2'd1; exp_occ[1] = 2'd2; exp_occ[2] = 2'd0; exp_occ[3] = 2'd1;
    n_cmp++; if (occ !== exp_occ) begin n_bad++; $display("FAIL clear_occ_before got=%h exp=%h", occ, exp_occ); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy_before got=%b exp=1", busy); end
    n_cmp++; if (!(fifo_clr === 1'b1 && wvalid === 1'b0 && req_ready === 4'b0)) begin n_bad++; $display("FAIL clear_cycle clr=%b wvalid=%b ready=%b exp=1/0/0000", fifo_clr, wvalid, req_ready); end
    @(negedge clk);
    clr = 1'b0; req_valid = 4'hF; #1;
    n_cmp++; if (occ !== 8'h00) begin n_bad++; $display("FAIL clear_occ_after got=%h exp=0", occ); end
    n_cmp++; if (!(wvalid === 1'b1 && wdata[W+1:W] === 2'd0)) begin n_bad++; $display("FAIL clear_restart wvalid=%b id=%0d exp=1/0", wvalid, wdata[W+1:W]); end
    n_cmp++; if (fifo_clr !== 1'b0) begin n_bad++; $display("FAIL clear_deassert got=%b exp=0", fifo_clr); end
    @(negedge clk);
  endtask

  task automatic test_random();
    do_clear();
    q.delete(); rr = 0; held = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int cnt[N];
      logic [N-1:0][1:0] e_occ;
      logic e_v;
      int e_id;
      bit do_pop;
      for (int i = 0; i < N; i++) begin
        if (i == held) begin
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = ($urandom_range(2) != 0);
          req_data[i]  = W'($urandom);
        end
      end
      wready = ($urandom_range(3) != 0);
      do_pop = 1'b0;
      if (q.size() > 0 && $urandom_range(1) == 1) begin
        rvalid = 1'b1; rready = ($urandom_range(3) != 0); rid = 2'(q[0]);
        do_pop = rready;
      end else begin
        rvalid = 1'b0; rready = 1'($urandom); rid = 2'($urandom);
      end
      #1;
      foreach (cnt[i]) cnt[i] = 0;
      foreach (q[j]) cnt[q[j]]++;
      for (int i = 0; i < N; i++) e_occ[i] = 2'(cnt[i]);
      e_v = 1'b0; e_id = 0;
      if (held >= 0) begin
        e_v = req_valid[held]; e_id = held;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (rr + k) % N;
          if (!e_v && req_valid[idx] && cnt[idx] < Q) begin e_v = 1'b1; e_id = idx; end
        end
      end
      n_cmp++; if (wvalid !== e_v) begin n_bad++; $display("FAIL rand_wvalid cyc=%0d got=%b exp=%b", cyc, wvalid, e_v); end
      if (e_v) begin
        n_cmp++; if (wdata !== {2'(e_id), req_data[e_id]}) begin n_bad++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, wdata, {2'(e_id), req_data[e_id]}); end
      end
      n_cmp++; if (req_ready !== (e_v ? 4'({3'b0, wready} << e_id) : 4'b0)) begin n_bad++; $display("FAIL rand_ready cyc=%0d got=%b exp_id=%0d wready=%b", cyc, req_ready, e_id, wready); end
      n_cmp++; if (occ !== e_occ) begin n_bad++; $display("FAIL rand_occ cyc=%0d got=%h exp=%h", cyc, occ, e_occ); end
      n_cmp++; if (busy !== (q.size() > 0 || held >= 0)) begin n_bad++; $display("FAIL rand_busy cyc=%0d got=%b", cyc, busy); end
      if (do_pop) void'(q.pop_front());
      if (e_v && wready) begin
        q.push_back(e_id); rr = (e_id + 1) % N; held = -1;
      end else if (e_v) begin
        held = e_id;
      end
      @(negedge clk);
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_quota();
    test_lock();
    test_simultaneous();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
